demux_stream_n_output: RTL and testbench

//  Registered 1-to-NOUT stream demultiplexer; inverse of the 2-input mux cells.

---
 rtl/demux_stream_n_output.sv | 116 +++++++++++
 tb/tb_demux_stream_n_output.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_n_output.sv
// Registered 1-to-NOUT stream demultiplexer with a one-entry valid/ready register per channel.
// Optional packet lock (in_last port plus IDLE/LOCKED FSM) is enabled by defining DEMUX_PKT_LOCK_EN.
module demux_stream_n_output #(
  parameter int WIDTH = 8,
  parameter int NOUT  = 3,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
`ifdef DEMUX_PKT_LOCK_EN
  input  logic                  in_last,
`endif
  output logic                  in_ready,
  output logic [NOUT*WIDTH-1:0] out_data,
  output logic [NOUT-1:0]       out_valid,
  input  logic [NOUT-1:0]       out_ready,
  output logic                  err_sel,
  output logic [7:0]            drop_cnt
);

  localparam logic [SELW:0] NOUT_EXT = (SELW+1)'(NOUT);

  logic [SELW-1:0] eff_sel;
  logic            in_range;
  logic            accept;
  logic            count_drop;
  logic [NOUT-1:0] fill;
  logic [NOUT-1:0] drain;

`ifdef DEMUX_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [SELW-1:0] lock_sel;

  // Inside a packet the destination is frozen; only the head beat can raise a drop.
  assign eff_sel    = (state == LOCKED) ? lock_sel : in_sel;
  assign count_drop = accept & ~in_range & (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_sel <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!in_last) begin
            lock_sel <= in_sel;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign eff_sel    = in_sel;
  assign count_drop = accept & ~in_range;
`endif

  // Width-extended compare keeps NOUT == 2**SELW from wrapping to zero.
  assign in_range = {1'b0, eff_sel} < NOUT_EXT;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  // Ready looks only at the destination register, never at in_valid.
  always_comb begin
    // NOTE: default first so every path assigns in_ready and no latch is inferred.
    in_ready = 1'b1;
    for (int k = 0; k < NOUT; k++) begin
      if (eff_sel == SELW'(k)) in_ready = ~out_valid[k] | out_ready[k];
    end
  end

  always_comb begin
    fill = '0;
    for (int k = 0; k < NOUT; k++) begin
      fill[k] = accept && (eff_sel == SELW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= '0;
      // NOTE: data registers are reset too, because out_data is observable as zero after reset.
      out_data  <= '0;
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (fill[k]) begin
          out_valid[k]                 <= 1'b1;
          out_data[k*WIDTH +: WIDTH]   <= in_data;
        end else if (drain[k]) begin
          out_valid[k]                 <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_sel <= count_drop;
      if (count_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_stream_n_output.sv
// Self-checking bench for demux_stream_n_output: per-channel scoreboard queues plus directed scenario tasks.
// Packet-lock scenario is compiled only when DEMUX_PKT_LOCK_EN is defined.
module tb_demux_stream_n_output;

  localparam int WIDTH = 8;
  localparam int NOUT  = 3;
  localparam int SELW  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [WIDTH-1:0]      in_data;
  logic [SELW-1:0]       in_sel;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [NOUT*WIDTH-1:0] out_data;
  logic [NOUT-1:0]       out_valid;
  logic [NOUT-1:0]       out_ready;
  logic                  err_sel;
  logic [7:0]            drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: beats expected to be held in each channel, plus error/drop model.
  logic [WIDTH-1:0] sb_q [NOUT][$];
  logic             exp_err;
  int               exp_drop;
  bit               exp_locked;
  logic [SELW-1:0]  exp_lock_sel;

  always #5 clk = ~clk;

  demux_stream_n_output #(.WIDTH(WIDTH), .NOUT(NOUT), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
`ifdef DEMUX_PKT_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel),
    .drop_cnt  (drop_cnt)
  );

  // Monitor on the falling edge: compare held state, then advance the model by the coming edge.
  always @(negedge clk) begin : monitor
    logic [SELW-1:0] s;
    int              si;
    bit              rdy_exp;
    bit              drop_now;
    bit              exp_v;
    if (!rst_n) begin
      for (int k = 0; k < NOUT; k++) sb_q[k].delete();
      exp_err      = 1'b0;
      exp_drop     = 0;
      exp_locked   = 1'b0;
      exp_lock_sel = '0;
    end else begin
      checks++;
      if (err_sel !== exp_err) begin
        failures++;
        $display("FAIL mon_err_sel t=%0t got %b want %b", $time, err_sel, exp_err);
      end
      checks++;
      if (drop_cnt !== 8'(exp_drop)) begin
        failures++;
        $display("FAIL mon_drop_cnt t=%0t got %0d want %0d", $time, drop_cnt, exp_drop);
      end
      for (int k = 0; k < NOUT; k++) begin
        exp_v = (sb_q[k].size() != 0);
        checks++;
        if (out_valid[k] !== exp_v) begin
          failures++;
          $display("FAIL mon_valid ch%0d t=%0t got %b want %b", k, $time, out_valid[k], exp_v);
        end else if (exp_v) begin
          checks++;
          if (out_data[k*WIDTH +: WIDTH] !== sb_q[k][0]) begin
            failures++;
            $display("FAIL mon_data ch%0d t=%0t got %h want %h", k, $time,
                     out_data[k*WIDTH +: WIDTH], sb_q[k][0]);
          end
        end
      end

      s  = exp_locked ? exp_lock_sel : in_sel;
      si = int'(s);
      if (si >= NOUT) rdy_exp = 1'b1;
      else            rdy_exp = (sb_q[si].size() == 0) || out_ready[si];
      checks++;
      if (in_ready !== rdy_exp) begin
        failures++;
        $display("FAIL mon_in_ready t=%0t sel=%0d got %b want %b", $time, si, in_ready, rdy_exp);
      end

      for (int k = 0; k < NOUT; k++) begin
        if (sb_q[k].size() != 0 && out_ready[k]) void'(sb_q[k].pop_front());
      end

      drop_now = 1'b0;
      if (in_valid && rdy_exp) begin
        if (si < NOUT) sb_q[si].push_back(in_data);
        else if (!exp_locked) drop_now = 1'b1;
`ifdef DEMUX_PKT_LOCK_EN
        if (!exp_locked && !in_last) begin
          exp_locked   = 1'b1;
          exp_lock_sel = in_sel;
        end else if (exp_locked && in_last) begin
          exp_locked = 1'b0;
        end
`endif
      end
      exp_err = drop_now;
      if (drop_now && exp_drop < 255) exp_drop++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 8'h3C;
    in_last   = 1'b1;
    out_ready = '0;
    repeat (2) cyc();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    smp();
    checks++;
    if (out_valid !== 3'b000) begin
      failures++; $display("FAIL reset_valid got %b want 000", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      failures++; $display("FAIL reset_data got %h want 0", out_data);
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_drop got %0d want 0", drop_cnt);
    end
    checks++;
    if (err_sel !== 1'b0) begin
      failures++; $display("FAIL reset_err got %b want 0", err_sel);
    end
  endtask

  task automatic test_fill_hold();
    cyc();
    in_data = 8'hA5; in_sel = 2'd1; in_valid = 1'b1; out_ready = '0;
    smp();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL hold_first_ready got %b want 1", in_ready);
    end
    cyc();
    in_data = 8'h5A;
    smp();
    checks++;
    if (out_valid !== 3'b010) begin
      failures++; $display("FAIL hold_valid got %b want 010", out_valid);
    end
    checks++;
    if (out_data[15:8] !== 8'hA5) begin
      failures++; $display("FAIL hold_data got %h want a5", out_data[15:8]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL hold_blocked cycle %0d got %b want 0", i, in_ready);
      end
      checks++;
      if (out_data[15:8] !== 8'hA5) begin
        failures++; $display("FAIL hold_stable cycle %0d got %h want a5", i, out_data[15:8]);
      end
      cyc();
      smp();
    end
    cyc();
    out_ready = 3'b010;
    smp();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL hold_release_ready got %b want 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    smp();
    checks++;
    if (out_valid !== 3'b010 || out_data[15:8] !== 8'h5A) begin
      failures++;
      $display("FAIL hold_replace got valid=%b data=%h want valid=010 data=5a", out_valid, out_data[15:8]);
    end
    cyc();
    out_ready = '0;
    smp();
    checks++;
    if (out_valid !== 3'b000) begin
      failures++; $display("FAIL hold_drained got %b want 000", out_valid);
    end
  endtask

  task automatic test_stream();
    cyc();
    out_ready = 3'b100; in_sel = 2'd2; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      smp();
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL stream_ready beat %0d got %b want 1", i, in_ready);
      end
      if (i > 1) begin
        checks++;
        if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'(i - 1)) begin
          failures++;
          $display("FAIL stream_out beat %0d got valid=%b data=%h want valid=1 data=%h",
                   i - 1, out_valid[2], out_data[23:16], 8'(i - 1));
        end
      end
      cyc();
    end
    in_valid = 1'b0;
    smp();
    checks++;
    if (out_valid !== 3'b100 || out_data[23:16] !== 8'h04) begin
      failures++;
      $display("FAIL stream_last got valid=%b data=%h want valid=100 data=04", out_valid, out_data[23:16]);
    end
    cyc();
    out_ready = '0;
  endtask

  task automatic test_back_to_back();
    cyc();
    out_ready = '0; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11;
    cyc();
    in_sel = 2'd2; in_data = 8'h22;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      checks++;
      if (out_valid !== 3'b101 || out_data[7:0] !== 8'h11 || out_data[23:16] !== 8'h22) begin
        failures++;
        $display("FAIL b2b_hold cycle %0d got valid=%b ch0=%h ch2=%h want valid=101 ch0=11 ch2=22",
                 i, out_valid, out_data[7:0], out_data[23:16]);
      end
      cyc();
    end
    out_ready = 3'b111;
    cyc();
    out_ready = '0;
    smp();
    checks++;
    if (out_valid !== 3'b000) begin
      failures++; $display("FAIL b2b_drained got %b want 000", out_valid);
    end
  endtask

  task automatic test_drop();
    cyc();
    in_sel = 2'd3; in_data = 8'hFF; in_valid = 1'b1; out_ready = '0;
    smp();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL drop_ready got %b want 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    smp();
    checks++;
    if (err_sel !== 1'b1 || out_valid !== 3'b000 || drop_cnt !== 8'd1) begin
      failures++;
      $display("FAIL drop_first got err=%b valid=%b cnt=%0d want err=1 valid=000 cnt=1",
               err_sel, out_valid, drop_cnt);
    end
    cyc();
    smp();
    checks++;
    if (err_sel !== 1'b0 || drop_cnt !== 8'd1) begin
      failures++;
      $display("FAIL drop_pulse_end got err=%b cnt=%0d want err=0 cnt=1", err_sel, drop_cnt);
    end
    cyc();
    in_valid = 1'b1;
    repeat (300) cyc();
    in_valid = 1'b0;
    smp();
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++; $display("FAIL drop_saturate got %0d want 255", drop_cnt);
    end
    cyc();
    smp();
    checks++;
    if (drop_cnt !== 8'd255 || err_sel !== 1'b0) begin
      failures++;
      $display("FAIL drop_stay got cnt=%0d err=%b want cnt=255 err=0", drop_cnt, err_sel);
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    out_ready = '0; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h77;
    cyc();
    in_sel = 2'd1; in_data = 8'h88;
    cyc();
    in_valid = 1'b0;
    smp();
    checks++;
    if (out_valid !== 3'b011) begin
      failures++; $display("FAIL midrst_pre got %b want 011", out_valid);
    end
    cyc();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    smp();
    checks++;
    if (out_valid !== 3'b000 || out_data !== '0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL midrst_post got valid=%b data=%h cnt=%0d want valid=000 data=0 cnt=0",
               out_valid, out_data, drop_cnt);
    end
  endtask

`ifdef DEMUX_PKT_LOCK_EN
  task automatic test_pkt_lock();
    cyc();
    out_ready = 3'b001; in_valid = 1'b1; in_sel = 2'd0; in_last = 1'b0; in_data = 8'hC1;
    cyc();
    in_sel = 2'd2; in_data = 8'hC2;
    smp();
    checks++;
    if (out_valid !== 3'b001 || out_data[7:0] !== 8'hC1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL pkt_beat1 got valid=%b ch0=%h ready=%b want valid=001 ch0=c1 ready=1",
               out_valid, out_data[7:0], in_ready);
    end
    cyc();
    in_data = 8'hC3; in_last = 1'b1;
    smp();
    checks++;
    if (out_valid !== 3'b001 || out_data[7:0] !== 8'hC2) begin
      failures++;
      $display("FAIL pkt_beat2 got valid=%b ch0=%h want valid=001 ch0=c2", out_valid, out_data[7:0]);
    end
    cyc();
    in_sel = 2'd2; in_data = 8'hD1; in_last = 1'b1;
    smp();
    checks++;
    if (out_valid !== 3'b001 || out_data[7:0] !== 8'hC3) begin
      failures++;
      $display("FAIL pkt_beat3 got valid=%b ch0=%h want valid=001 ch0=c3", out_valid, out_data[7:0]);
    end
    cyc();
    in_valid = 1'b0;
    smp();
    checks++;
    if (out_valid !== 3'b100 || out_data[23:16] !== 8'hD1) begin
      failures++;
      $display("FAIL pkt_next got valid=%b ch2=%h want valid=100 ch2=d1", out_valid, out_data[23:16]);
    end
    cyc();
    out_ready = 3'b111;
    cyc();
    out_ready = '0;
  endtask
`endif

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    in_last   = 1'b1;
    out_ready = '0;
    test_reset();
    test_fill_hold();
    test_stream();
    test_back_to_back();
    test_drop();
    test_reset_mid();
`ifdef DEMUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
